miriscv_data_arbiter: RTL and testbench

MIRISCV_DATA_ARBITER -- requirements
Module: miriscv_data_arbiter

---
 rtl/miriscv_arb_pkg.sv | 20 ++
 rtl/miriscv_rr_pick2.sv | 20 ++
 rtl/miriscv_data_arbiter.sv | 116 +++++++++++
 tb/tb_miriscv_data_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/miriscv_arb_pkg.sv
// Shared types for the two-master data-memory arbiter: FSM encoding, the
// latched memory command and the requester count.
package miriscv_arb_pkg;

  localparam int ARB_N = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_cmd_t;

endpackage

// File: rtl/miriscv_rr_pick2.sv
// Combinational two-way picker. On a conflict the requester that did not own
// the previous transaction wins, unless fixed priority forces m0.
module miriscv_rr_pick2 (
  input  logic [1:0] req_i,
  input  logic       last_owner_i,
  input  logic       fixed_prio_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = (fixed_prio_i || last_owner_i) ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/miriscv_data_arbiter.sv
// Two-master data-memory arbiter: grant, issue one cycle later, respond the
// cycle after that; a new grant can overlap the response cycle.
module miriscv_data_arbiter
  import miriscv_arb_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_be_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  output logic        m0_gnt_o,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,

  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_be_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  output logic        m1_gnt_o,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,

  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);

  localparam logic FIXED_PRIO_BIT = (FIXED_PRIO != 0);

  arb_state_t state_q, state_d;
  mem_cmd_t   cmd_q, cmd_d;
  logic       owner_q, owner_d;

  logic [ARB_N-1:0] req;
  logic [ARB_N-1:0] pick;
  logic [ARB_N-1:0] gnt;
  logic             arb_en;
  logic             issue;
  logic             resp;
  mem_cmd_t         m0_cmd, m1_cmd, win_cmd;

  assign req = {m1_req_i, m0_req_i};

  miriscv_rr_pick2 u_pick (
    .req_i        (req),
    .last_owner_i (owner_q),
    .fixed_prio_i (FIXED_PRIO_BIT),
    .gnt_o        (pick)
  );

  // Arbitration is only open when the memory slot for the next cycle is free.
  assign arb_en = !rst_i && (state_q == IDLE || state_q == RESP);
  assign gnt    = arb_en ? pick : '0;

  assign m0_cmd  = '{we: m0_we_i, be: m0_be_i, addr: m0_addr_i, wdata: m0_wdata_i};
  assign m1_cmd  = '{we: m1_we_i, be: m1_be_i, addr: m1_addr_i, wdata: m1_wdata_i};
  assign win_cmd = gnt[1] ? m1_cmd : m0_cmd;

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    owner_d = owner_q;
    case (state_q)
      IDLE, RESP: begin
        if (|gnt) begin
          state_d = ISSUE;
          cmd_d   = win_cmd;
          owner_d = gnt[1];
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE:   state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      owner_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      owner_q <= owner_d;
    end
  end

  assign issue = !rst_i && (state_q == ISSUE);
  assign resp  = !rst_i && (state_q == RESP);

  assign m0_gnt_o = gnt[0];
  assign m1_gnt_o = gnt[1];

  assign mem_req_o   = issue;
  assign mem_we_o    = issue && cmd_q.we;
  assign mem_be_o    = rst_i ? '0 : cmd_q.be;
  assign mem_addr_o  = rst_i ? '0 : cmd_q.addr;
  assign mem_wdata_o = rst_i ? '0 : cmd_q.wdata;

  assign m0_rvalid_o = resp && !owner_q;
  assign m1_rvalid_o = resp && owner_q;
  assign m0_rdata_o  = m0_rvalid_o ? mem_rdata_i : '0;
  assign m1_rdata_o  = m1_rvalid_o ? mem_rdata_i : '0;

endmodule

// File: tb/tb_miriscv_data_arbiter.sv
// Bench for the data arbiter: directed latency/arbitration/reset cases plus
// random traffic checked against a grant-ordered scoreboard.
module tb_miriscv_data_arbiter;
  import miriscv_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = '0;
  logic [1:0]  we  = '0;
  logic [3:0]  be    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];

  logic        m0_gnt, m1_gnt, m0_rv, m1_rv;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic        fp_m0_gnt, fp_m1_gnt, fp_m0_rv, fp_m1_rv;
  logic [31:0] fp_m0_rdata, fp_m1_rdata;
  logic        fp_mem_req, fp_mem_we;
  logic [3:0]  fp_mem_be;
  logic [31:0] fp_mem_addr, fp_mem_wdata, fp_mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;
  int gnt_cnt  = 0;
  int rv_cnt   = 0;

  int          rq_id   [$];
  logic [31:0] rq_data [$];
  mem_cmd_t    mq      [$];

  always #5 clk = ~clk;

  miriscv_data_arbiter #(.FIXED_PRIO(0)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_req_i(req[0]), .m0_we_i(we[0]), .m0_be_i(be[0]), .m0_addr_i(addr[0]), .m0_wdata_i(wdata[0]),
    .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rv), .m0_rdata_o(m0_rdata),
    .m1_req_i(req[1]), .m1_we_i(we[1]), .m1_be_i(be[1]), .m1_addr_i(addr[1]), .m1_wdata_i(wdata[1]),
    .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rv), .m1_rdata_o(m1_rdata),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  miriscv_data_arbiter #(.FIXED_PRIO(1)) dut_fp (
    .clk_i(clk), .rst_i(rst),
    .m0_req_i(req[0]), .m0_we_i(we[0]), .m0_be_i(be[0]), .m0_addr_i(addr[0]), .m0_wdata_i(wdata[0]),
    .m0_gnt_o(fp_m0_gnt), .m0_rvalid_o(fp_m0_rv), .m0_rdata_o(fp_m0_rdata),
    .m1_req_i(req[1]), .m1_we_i(we[1]), .m1_be_i(be[1]), .m1_addr_i(addr[1]), .m1_wdata_i(wdata[1]),
    .m1_gnt_o(fp_m1_gnt), .m1_rvalid_o(fp_m1_rv), .m1_rdata_o(fp_m1_rdata),
    .mem_req_o(fp_mem_req), .mem_we_o(fp_mem_we), .mem_be_o(fp_mem_be), .mem_addr_o(fp_mem_addr),
    .mem_wdata_o(fp_mem_wdata), .mem_rdata_i(fp_mem_rdata)
  );

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : {a[15:0], ~a[15:0]};
  endfunction

  // Memory answers exactly one cycle after an accepted request.
  always @(posedge clk) begin
    mem_rdata    <= mem_req ? mem_fn(mem_addr) : 32'h0;
    fp_mem_rdata <= fp_mem_req ? mem_fn(fp_mem_addr) : 32'h0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  // Continuous monitor on the round-robin instance.
  mem_cmd_t    mon_c;
  int          mon_id;
  logic [31:0] mon_d;
  always @(posedge clk) begin
    #3;
    if (rst) begin
      chk("rst_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd0);
      chk("rst_outs", {29'd0, mem_req, m1_rv, m0_rv}, 32'd0);
      rq_id.delete();
      rq_data.delete();
      mq.delete();
    end else begin
      chk("onehot", {30'd0, m0_gnt & m1_gnt, m0_rv & m1_rv}, 32'd0);
      chk("gnt_without_req", {31'd0, (m0_gnt & ~req[0]) | (m1_gnt & ~req[1])}, 32'd0);
      if (!m0_rv) chk("m0_rdata_idle", m0_rdata, 32'd0);
      if (!m1_rv) chk("m1_rdata_idle", m1_rdata, 32'd0);
      if (mem_req) begin
        if (mq.size() == 0) chk("memreq_unexpected", 32'd1, 32'd0);
        else begin
          mon_c = mq.pop_front();
          chk("mem_we", {31'd0, mem_we}, {31'd0, mon_c.we});
          chk("mem_be", {28'd0, mem_be}, {28'd0, mon_c.be});
          chk("mem_addr", mem_addr, mon_c.addr);
          chk("mem_wdata", mem_wdata, mon_c.wdata);
        end
      end else begin
        chk("mem_we_idle", {31'd0, mem_we}, 32'd0);
      end
      if (m0_rv || m1_rv) begin
        rv_cnt++;
        if (rq_id.size() == 0) chk("rvalid_unexpected", 32'd1, 32'd0);
        else begin
          mon_id = rq_id.pop_front();
          mon_d  = rq_data.pop_front();
          chk("rv_owner", {31'd0, m1_rv}, mon_id);
          chk("rv_rdata", m1_rv ? m1_rdata : m0_rdata, mon_d);
        end
      end
      if (m0_gnt || m1_gnt) begin
        gnt_cnt++;
        mon_id = m1_gnt ? 1 : 0;
        mq.push_back('{we: we[mon_id], be: be[mon_id], addr: addr[mon_id], wdata: wdata[mon_id]});
        rq_id.push_back(mon_id);
        rq_data.push_back(mem_fn(addr[mon_id]));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    int exp_g;
    int issued;
    int g0, r0;
    int max_wait;
    logic [1:0] pend;
    logic [1:0] granted_prev;
    int age [2];

    for (int k = 0; k < 2; k++) begin
      be[k] = '0; addr[k] = '0; wdata[k] = '0;
    end

    // Reset, then the first IDLE cycle must show all-zero outputs.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    settle();
    chk("idle0_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd0);
    chk("idle0_mem", {29'd0, mem_req, mem_we, m0_rv | m1_rv}, 32'd0);
    chk("idle0_fields", mem_addr | mem_wdata | {28'd0, mem_be}, 32'd0);
    chk("idle0_rdata", m0_rdata | m1_rdata, 32'd0);

    // Conflict: both hold requests; RR alternates starting with m0, FP keeps m0.
    step();
    req = 2'b11; we = 2'b00;
    be[0] = 4'hF; addr[0] = 32'h10; wdata[0] = 32'h0;
    be[1] = 4'hF; addr[1] = 32'h20; wdata[1] = 32'h0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) step();
      settle();
      exp_g = (i % 2) ? 0 : (((i / 2) % 2) ? 2 : 1);
      chk($sformatf("rr_gnt_c%0d", i), {30'd0, m1_gnt, m0_gnt}, exp_g);
      chk($sformatf("fp_gnt_c%0d", i), {30'd0, fp_m1_gnt, fp_m0_gnt}, (i % 2) ? 0 : 1);
    end
    step(); req = 2'b00; settle();
    repeat (2) begin step(); settle(); end

    // Single read from m0.
    step();
    req[0] = 1'b1; we[0] = 1'b0; be[0] = 4'hF; addr[0] = 32'h100;
    settle();
    chk("rd_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd1);
    step(); req[0] = 1'b0; settle();
    chk("rd_memreq", {31'd0, mem_req}, 32'd1);
    chk("rd_addr", mem_addr, 32'h100);
    chk("rd_be", {28'd0, mem_be}, 32'hF);
    chk("rd_rv_early", {30'd0, m1_rv, m0_rv}, 32'd0);
    step(); settle();
    chk("rd_rvalid", {30'd0, m1_rv, m0_rv}, 32'd1);
    chk("rd_rdata", m0_rdata, 32'hDEADBEEF);
    chk("rd_m1_quiet", m1_rdata | {31'd0, m1_gnt}, 32'd0);
    step(); settle();

    // Write pass-through from m1.
    step();
    req[1] = 1'b1; we[1] = 1'b1; be[1] = 4'b1000; addr[1] = 32'h203; wdata[1] = 32'hABABABAB;
    settle();
    chk("wr_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd2);
    step(); req[1] = 1'b0; we[1] = 1'b0; settle();
    chk("wr_issue", {31'd0, mem_req}, 32'd1);
    chk("wr_we", {31'd0, mem_we}, 32'd1);
    chk("wr_be", {28'd0, mem_be}, 32'h8);
    chk("wr_addr", mem_addr, 32'h203);
    chk("wr_wdata", mem_wdata, 32'hABABABAB);
    step(); settle();
    chk("wr_rvalid", {30'd0, m1_rv, m0_rv}, 32'd2);
    step(); settle();
    chk("wr_hold_idle", {31'd0, mem_req | mem_we}, 32'd0);
    chk("wr_hold_addr", mem_addr, 32'h203);
    chk("wr_hold_wdata", mem_wdata, 32'hABABABAB);

    // Reset asserted during ISSUE abandons the transaction.
    step();
    req[0] = 1'b1; we[0] = 1'b0; be[0] = 4'hF; addr[0] = 32'h44;
    settle();
    chk("rst_mid_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd1);
    step(); req[0] = 1'b0; rst = 1'b1; settle();
    chk("rst_mid_memreq", {31'd0, mem_req}, 32'd0);
    step(); rst = 1'b0; settle();
    chk("rst_after_memreq", {31'd0, mem_req}, 32'd0);
    chk("rst_after_rv", {30'd0, m1_rv, m0_rv}, 32'd0);
    chk("rst_after_state", 32'(dut.state_q), 32'(IDLE));
    for (int i = 0; i < 3; i++) begin
      step(); settle();
      chk("rst_no_rv", {30'd0, m1_rv, m0_rv}, 32'd0);
    end

    // Randomised traffic.
    issued = 0; g0 = gnt_cnt; r0 = rv_cnt; max_wait = 0;
    pend = '0; granted_prev = '0; age[0] = 0; age[1] = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      step();
      for (int k = 0; k < 2; k++) begin
        if (pend[k] && granted_prev[k]) pend[k] = 1'b0;
        if (!pend[k] && ($urandom_range(0, 99) < 45)) begin
          pend[k]  = 1'b1;
          we[k]    = 1'($urandom_range(0, 1));
          be[k]    = 4'($urandom);
          addr[k]  = $urandom;
          wdata[k] = $urandom;
          issued++;
        end
      end
      req = pend;
      settle();
      granted_prev = {m1_gnt, m0_gnt};
      for (int k = 0; k < 2; k++) begin
        if (pend[k] && !granted_prev[k]) age[k]++;
        else age[k] = 0;
        if (age[k] > max_wait) max_wait = age[k];
      end
    end
    // Let the last granted requesters see their grant, then drain.
    step();
    for (int k = 0; k < 2; k++) if (pend[k] && granted_prev[k]) pend[k] = 1'b0;
    req = pend;
    for (int i = 0; i < 12 && pend != 2'b00; i++) begin
      settle();
      granted_prev = {m1_gnt, m0_gnt};
      step();
      for (int k = 0; k < 2; k++) if (pend[k] && granted_prev[k]) pend[k] = 1'b0;
      req = pend;
    end
    chk("rand_drain", {30'd0, pend}, 32'd0);
    req = '0;
    repeat (4) begin step(); settle(); end
    chk("rand_max_wait_le4", {31'd0, max_wait <= 4}, 32'd1);
    chk("rand_gnt_count", gnt_cnt - g0, issued);
    chk("rand_rv_count", rv_cnt - r0, issued);
    chk("rand_sb_empty", rq_id.size() + mq.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
